// File: rtl/mips_main_control_fsm_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_main_control_fsm_if : instruction fields in, datapath controls out
// Revision 1.0
// ---------------------------------------------------------------------------
interface mips_main_control_fsm_if #(
   parameter int COUNT_W = 32
);
   logic [5:0]         opcode;
   logic [5:0]         funct;
   logic               IorD;
   logic               MemWrite;
   logic               IRWrite;
   logic               RegDst;
   logic               MemtoReg;
   logic               RegWrite;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [1:0]         PCSrc;
   logic [1:0]         ALUOp;
   logic               PCWrite;
   logic               Branch;
   logic               BranchNe;
   logic               illegal_op;
   logic [COUNT_W-1:0] instr_count;

   modport master (
      input  opcode, funct,
      output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, PCSrc, ALUOp, PCWrite, Branch, BranchNe, illegal_op,
             instr_count
   );

   modport slave (
      output opcode, funct,
      input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
             ALUSrcB, PCSrc, ALUOp, PCWrite, Branch, BranchNe, illegal_op,
             instr_count
   );
endinterface
`default_nettype wire

// File: rtl/mips_main_control_fsm.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mips_main_control_fsm : multi-cycle MIPS main controller (Moore FSM)
// Revision 1.0
// ---------------------------------------------------------------------------
module mips_main_control_fsm #(
   parameter int COUNT_W = 32
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   mips_main_control_fsm_if.master     bus
);

   localparam logic [5:0] C_OP_RTYPE = 6'h00;
   localparam logic [5:0] C_OP_J     = 6'h02;
   localparam logic [5:0] C_OP_BEQ   = 6'h04;
   localparam logic [5:0] C_OP_BNE   = 6'h05;
   localparam logic [5:0] C_OP_ADDI  = 6'h08;
   localparam logic [5:0] C_OP_LW    = 6'h23;
   localparam logic [5:0] C_OP_SW    = 6'h2B;
   localparam logic [5:0] C_FN_JR    = 6'h08;

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMREAD  = 4'd3,
      S_MEMWB    = 4'd4,
      S_MEMWRITE = 4'd5,
      S_EXECUTE  = 4'd6,
      S_ALUWB    = 4'd7,
      S_BEQEX    = 4'd8,
      S_BNEEX    = 4'd9,
      S_ADDIEX   = 4'd10,
      S_ADDIWB   = 4'd11,
      S_JEX      = 4'd12,
      S_JREX     = 4'd13
   } state_t;

   typedef struct packed {
      logic       iord;
      logic       mem_write;
      logic       ir_write;
      logic       reg_dst;
      logic       memto_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] pc_src;
      logic [1:0] alu_op;
      logic       pc_write;
      logic       branch;
      logic       branch_ne;
   } ctrl_t;

   localparam ctrl_t C_CTRL_FETCH = '{ir_write: 1'b1, pc_write: 1'b1,
                                      alu_src_b: 2'b01, default: '0};

   state_t             state_q, state_d;
   ctrl_t              ctrl_q, ctrl_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               illegal_w;

   always_comb begin
      state_d   = S_FETCH;
      illegal_w = 1'b0;
      case (state_q)
         S_FETCH:    state_d = S_DECODE;
         S_DECODE: begin
            case (bus.opcode)
               C_OP_LW, C_OP_SW: state_d = S_MEMADR;
               C_OP_RTYPE:       state_d = (bus.funct == C_FN_JR) ? S_JREX : S_EXECUTE;
               C_OP_BEQ:         state_d = S_BEQEX;
               C_OP_BNE:         state_d = S_BNEEX;
               C_OP_ADDI:        state_d = S_ADDIEX;
               C_OP_J:           state_d = S_JEX;
               default: begin
                  state_d   = S_FETCH;
                  illegal_w = 1'b1;
               end
            endcase
         end
         S_MEMADR:   state_d = (bus.opcode == C_OP_LW) ? S_MEMREAD : S_MEMWRITE;
         S_MEMREAD:  state_d = S_MEMWB;
         S_EXECUTE:  state_d = S_ALUWB;
         S_ADDIEX:   state_d = S_ADDIWB;
         default:    state_d = S_FETCH;
      endcase
   end

   // Outputs are decoded from the next state so the registered copy lines up
   // with the state the FSM is in, keeping Moore timing without output glitches.
   always_comb begin
      ctrl_d = '0;
      case (state_d)
         S_FETCH:    ctrl_d = C_CTRL_FETCH;
         S_DECODE:   ctrl_d.alu_src_b = 2'b11;
         S_MEMADR: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
         end
         S_MEMREAD:  ctrl_d.iord = 1'b1;
         S_MEMWB: begin
            ctrl_d.memto_reg = 1'b1;
            ctrl_d.reg_write = 1'b1;
         end
         S_MEMWRITE: begin
            ctrl_d.iord      = 1'b1;
            ctrl_d.mem_write = 1'b1;
         end
         S_EXECUTE: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_op    = 2'b10;
         end
         S_ALUWB: begin
            ctrl_d.reg_dst   = 1'b1;
            ctrl_d.reg_write = 1'b1;
         end
         S_BEQEX, S_BNEEX: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_op    = 2'b01;
            ctrl_d.pc_src    = 2'b01;
            ctrl_d.branch    = (state_d == S_BEQEX);
            ctrl_d.branch_ne = (state_d == S_BNEEX);
         end
         S_ADDIEX: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_src_b = 2'b10;
         end
         S_ADDIWB:   ctrl_d.reg_write = 1'b1;
         S_JEX: begin
            ctrl_d.pc_src   = 2'b10;
            ctrl_d.pc_write = 1'b1;
         end
         // jr reuses the R-type ALU path: rs + $zero lands on ALUResult
         S_JREX: begin
            ctrl_d.alu_src_a = 1'b1;
            ctrl_d.alu_op    = 2'b10;
            ctrl_d.pc_write  = 1'b1;
         end
         default:    ctrl_d = '0;
      endcase
   end

   always_comb begin
      count_d = count_q;
      case (state_q)
         S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQEX, S_BNEEX, S_ADDIWB, S_JEX, S_JREX:
            count_d = count_q + 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         ctrl_q  <= C_CTRL_FETCH;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         count_q <= count_d;
      end
   end

   assign bus.IorD        = ctrl_q.iord;
   assign bus.MemWrite    = ctrl_q.mem_write;
   assign bus.IRWrite     = ctrl_q.ir_write;
   assign bus.RegDst      = ctrl_q.reg_dst;
   assign bus.MemtoReg    = ctrl_q.memto_reg;
   assign bus.RegWrite    = ctrl_q.reg_write;
   assign bus.ALUSrcA     = ctrl_q.alu_src_a;
   assign bus.ALUSrcB     = ctrl_q.alu_src_b;
   assign bus.PCSrc       = ctrl_q.pc_src;
   assign bus.ALUOp       = ctrl_q.alu_op;
   assign bus.PCWrite     = ctrl_q.pc_write;
   assign bus.Branch      = ctrl_q.branch;
   assign bus.BranchNe    = ctrl_q.branch_ne;
   assign bus.illegal_op  = illegal_w;
   assign bus.instr_count = count_q;

endmodule
`default_nettype wire

// File: doc/mips_main_control_fsm.md
# mips_main_control_fsm

Multi-cycle MIPS main controller: a Moore state machine that sequences fetch, decode, execute, memory and write-back steps for each instruction and drives the datapath enables and muxes. It is the producer of the 2-bit `ALUOp` code that the ALU decoder consumes with `funct` to form `ALUControl`. It sits between the instruction register and the datapath, one instance per core.

## Interface
- `COUNT_W`, default 32: width of the retired-instruction counter.
- `clk  in  1`: core clock; all state updates on rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `opcode  in  6`: IR[31:26]; valid from DECODE onward.
- `funct  in  6`: IR[5:0]; used only to detect `jr`.
- `IorD  out  1`, `MemWrite  out  1`, `IRWrite  out  1`, `RegDst  out  1`, `MemtoReg  out  1`, `RegWrite  out  1`, `ALUSrcA  out  1`: datapath controls.
- `ALUSrcB  out  2`, `PCSrc  out  2`, `ALUOp  out  2`: datapath mux selects / ALU class.
- `PCWrite  out  1`: unconditional PC enable.
- `Branch  out  1`, `BranchNe  out  1`: qualified externally with Zero / !Zero to form PCEn.
- `illegal_op  out  1`: one-cycle pulse in DECODE for an unsupported opcode/funct.
- `instr_count  out  COUNT_W`: instructions completed since reset.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTE, ALUWB, BEQEX, BNEEX, ADDIEX, ADDIWB, JEX, JREX. State register only; all outputs decode from current state (plus `opcode`/`funct` for `illegal_op`). Any unlisted output is 0 in that state.
- FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALUOp=00 -> DECODE.
- DECODE: ALUSrcB=11, ALUOp=00. Next by opcode: 0x23/0x2B -> MEMADR; 0x00 with funct 0x08 -> JREX; 0x00 other funct -> EXECUTE; 0x04 -> BEQEX; 0x05 -> BNEEX; 0x08 -> ADDIEX; 0x02 -> JEX; else -> FETCH with `illegal_op`=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> MEMREAD if 0x23, else MEMWRITE.
- MEMREAD: IorD=1 -> MEMWB. MEMWB: MemtoReg=1, RegWrite=1 -> FETCH.
- MEMWRITE: IorD=1, MemWrite=1 -> FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 -> ALUWB. ALUWB: RegDst=1, RegWrite=1 -> FETCH.
- BEQEX / BNEEX: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 (BEQEX) or BranchNe=1 (BNEEX) -> FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 -> ADDIWB. ADDIWB: RegWrite=1 -> FETCH.
- JEX: PCSrc=10, PCWrite=1 -> FETCH.
- JREX: ALUSrcA=1, ALUSrcB=00, ALUOp=10, PCSrc=00, PCWrite=1 -> FETCH (ALU adds rs + $zero).
- ALUOp is never 11. Unreachable state encodings -> FETCH next cycle, all outputs 0.
- `instr_count` increments by 1 on the final state of each legal instruction (MEMWB, MEMWRITE, ALUWB, BEQEX, BNEEX, ADDIWB, JEX, JREX); illegal opcodes do not count; wraps modulo 2^COUNT_W.

## Timing
- `rst` high at an edge: state <= FETCH, `instr_count` <= 0, regardless of current state (reset mid-instruction aborts it, no count). First cycle after reset shows FETCH outputs: IRWrite=1, PCWrite=1, ALUSrcB=01, all others 0, `illegal_op`=0.
- Cycles per instruction, FETCH to FETCH: lw 5; sw, R-type, addi 4; beq, bne, j, jr 3; illegal 2.
- `instr_count` visible incremented the cycle after the final state (i.e. in the next FETCH).
- `opcode`/`funct` sampled combinationally in DECODE and MEMADR only; changes elsewhere have no effect.
- No handshake or stall: one state per clock.

## Test plan
- Reset: hold `rst` 2 cycles in any state -> FETCH outputs, `instr_count`=0, next state DECODE.
- lw (0x23): FETCH, DECODE, MEMADR, MEMREAD, MEMWB; MemtoReg=1 & RegWrite=1 only in cycle 5; `instr_count` 0->1.
- R-type add (0x00/0x20) then jr (0x00/0x08): EXECUTE ALUOp=10 then ALUWB RegDst=1; jr goes DECODE->JREX with PCWrite=1, PCSrc=00, 3 cycles.
- beq (0x04) and bne (0x05): third cycle ALUOp=01, PCSrc=01, Branch=1 / BranchNe=1 respectively, PCWrite=0.
- Illegal opcode 0x3F: `illegal_op`=1 in DECODE only, return to FETCH, `instr_count` unchanged.
- Reset asserted in MEMREAD of lw: next cycle FETCH, no RegWrite pulse, count not incremented; 2^COUNT_W completions (COUNT_W=4, 16 j's) -> count wraps to 0.
